// File: rtl/fb_bank_controller.sv
// Double-buffer bank manager between the SPI frame loader and the LED scan engine.
// Loader writes land in the back bank; banks swap only on a scanner end-of-frame.
module fb_bank_controller #(
    parameter int rows     = 8,
    parameter int columns  = 32,
    parameter int segments = 1,
    parameter int bitwidth = 8,
    localparam int row_w   = (rows > 1) ? $clog2(rows) : 1,
    localparam int col_w   = (columns > 1) ? $clog2(columns) : 1,
    localparam int data_w  = segments * bitwidth * 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_wen,
    input  logic [row_w-1:0]  ld_wrow,
    input  logic [col_w-1:0]  ld_wcol,
    input  logic [data_w-1:0] ld_wdata,
    input  logic              ld_loaded,
    output logic              ld_ready,
    input  logic              frame_end,
    output logic              disp_bank,
    output logic              mem_wen,
    output logic              mem_wbank,
    output logic [row_w-1:0]  mem_wrow,
    output logic [col_w-1:0]  mem_wcol,
    output logic [data_w-1:0] mem_wdata,
    output logic [7:0]        swap_count,
    output logic [7:0]        drop_count,
    output logic [1:0]        state_dbg
);

    localparam logic [1:0] ST_LOADING = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_SWAP    = 2'd2;

    // Loader handshake: a write is accepted in any cycle ld_wen is high while
    // the state register holds LOADING; there is no back-pressure on a single
    // word, and ld_ready is only a frame-level hint that LOADING is active.
    logic [1:0] state;
    logic [1:0] state_next;
    logic       wr_accept;
    logic       wr_drop;

    assign wr_accept = ld_wen && (state == ST_LOADING);
    assign wr_drop   = ld_wen && (state != ST_LOADING);
    assign state_dbg = state;

    // frame_end is deliberately ignored in LOADING, even alongside ld_loaded,
    // so a swap always waits for a full scanner frame after the load completes.
    always_comb begin
        state_next = state;
        case (state)
            ST_LOADING: if (ld_loaded) state_next = ST_PENDING;
            ST_PENDING: if (frame_end) state_next = ST_SWAP;
            ST_SWAP:    state_next = ST_LOADING;
            default:    state_next = ST_LOADING;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_LOADING;
            ld_ready <= 1'b1;
        end else begin
            state    <= state_next;
            ld_ready <= (state_next == ST_LOADING);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_bank  <= 1'b0;
            swap_count <= 8'd0;
        end else if (state == ST_SWAP) begin
            disp_bank  <= ~disp_bank;
            swap_count <= swap_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= 8'd0;
        end else if (wr_drop && (drop_count != 8'hff)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

    // Target bank is sampled at issue, so a write just before SWAP still
    // lands in the bank that was back when it was accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wen   <= 1'b0;
            mem_wbank <= 1'b0;
            mem_wrow  <= '0;
            mem_wcol  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_wen <= wr_accept;
            if (wr_accept) begin
                mem_wbank <= ~disp_bank;
                mem_wrow  <= ld_wrow;
                mem_wcol  <= ld_wcol;
                mem_wdata <= ld_wdata;
            end
        end
    end

endmodule

// File: tb/tb_fb_bank_controller.sv
// Directed bench for fb_bank_controller: load, swap, drop counting, reset and wrap cases.
module tb_fb_bank_controller;

    localparam logic [1:0] ST_LOADING = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_SWAP    = 2'd2;

    logic        clk;
    logic        rst;
    logic        ld_wen;
    logic [2:0]  ld_wrow;
    logic [4:0]  ld_wcol;
    logic [23:0] ld_wdata;
    logic        ld_loaded;
    logic        ld_ready;
    logic        frame_end;
    logic        disp_bank;
    logic        mem_wen;
    logic        mem_wbank;
    logic [2:0]  mem_wrow;
    logic [4:0]  mem_wcol;
    logic [23:0] mem_wdata;
    logic [7:0]  swap_count;
    logic [7:0]  drop_count;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    fb_bank_controller dut (
        .clk(clk), .rst(rst),
        .ld_wen(ld_wen), .ld_wrow(ld_wrow), .ld_wcol(ld_wcol), .ld_wdata(ld_wdata),
        .ld_loaded(ld_loaded), .ld_ready(ld_ready), .frame_end(frame_end),
        .disp_bank(disp_bank), .mem_wen(mem_wen), .mem_wbank(mem_wbank),
        .mem_wrow(mem_wrow), .mem_wcol(mem_wcol), .mem_wdata(mem_wdata),
        .swap_count(swap_count), .drop_count(drop_count), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_swap;
        logic       exp_disp;

        rst = 1'b1; ld_wen = 1'b0; ld_wrow = '0; ld_wcol = '0; ld_wdata = '0;
        ld_loaded = 1'b0; frame_end = 1'b0;
        tick();
        tick();

        // reset state
        check("rst_ready", ld_ready, 1);
        check("rst_disp", disp_bank, 0);
        check("rst_mem_wen", mem_wen, 0);
        check("rst_swap", swap_count, 0);
        check("rst_drop", drop_count, 0);
        check("rst_state", state_dbg, ST_LOADING);
        rst = 1'b0;
        tick();
        check("idle_mem_wen", mem_wen, 0);

        // full frame of writes into back bank 1
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 32; c++) begin
                ld_wen = 1'b1; ld_wrow = r[2:0]; ld_wcol = c[4:0]; ld_wdata = 24'hA5A5A5;
                tick();
                check("wr_wen", mem_wen, 1);
                check("wr_bank", mem_wbank, 1);
                check("wr_row", mem_wrow, r);
                check("wr_col", mem_wcol, c);
                check("wr_data", mem_wdata, 24'hA5A5A5);
                check("wr_ready", ld_ready, 1);
            end
        end
        ld_wen = 1'b0;
        tick();
        check("wr_end_wen", mem_wen, 0);
        check("wr_end_drop", drop_count, 0);

        // frame_end in LOADING with nothing pending
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check("fe_idle_disp", disp_bank, 0);
        check("fe_idle_state", state_dbg, ST_LOADING);

        // loaded, then 5 dropped writes, frame_end 10 cycles after loaded
        ld_loaded = 1'b1;
        tick();
        ld_loaded = 1'b0;
        check("pend_state", state_dbg, ST_PENDING);
        check("pend_ready", ld_ready, 0);
        for (int i = 0; i < 5; i++) begin
            ld_wen = 1'b1; ld_wrow = 3'd2; ld_wcol = 5'd3; ld_wdata = 24'h111111;
            tick();
            check("pend_no_wen", mem_wen, 0);
        end
        ld_wen = 1'b0;
        check("drop5", drop_count, 5);
        for (int i = 0; i < 4; i++) tick();
        check("pend_hold_disp", disp_bank, 0);
        check("pend_hold_ready", ld_ready, 0);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check("swap_state", state_dbg, ST_SWAP);
        check("swap_ready", ld_ready, 0);
        check("swap_disp_pre", disp_bank, 0);
        tick();
        check("swap1_disp", disp_bank, 1);
        check("swap1_count", swap_count, 1);
        check("swap1_ready", ld_ready, 1);
        check("swap1_state", state_dbg, ST_LOADING);
        ld_wen = 1'b1; ld_wrow = 3'd7; ld_wcol = 5'd31; ld_wdata = 24'h5A5A5A;
        tick();
        ld_wen = 1'b0;
        check("post_swap_wen", mem_wen, 1);
        check("post_swap_bank", mem_wbank, 0);
        check("post_swap_data", mem_wdata, 24'h5A5A5A);
        tick();
        check("post_swap_pulse", mem_wen, 0);

        // drop counter saturation (5 already counted)
        ld_loaded = 1'b1;
        tick();
        ld_loaded = 1'b0;
        for (int i = 0; i < 300; i++) begin
            ld_wen = 1'b1;
            tick();
            if (i == 244) check("drop250", drop_count, 250);
        end
        ld_wen = 1'b0;
        check("drop_sat", drop_count, 255);
        check("sat_state", state_dbg, ST_PENDING);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
        check("swap2_disp", disp_bank, 0);
        check("swap2_count", swap_count, 2);

        // ld_loaded with frame_end in the same cycle: swap waits
        ld_loaded = 1'b1; frame_end = 1'b1;
        tick();
        ld_loaded = 1'b0; frame_end = 1'b0;
        check("same_state", state_dbg, ST_PENDING);
        for (int i = 0; i < 3; i++) tick();
        check("same_no_swap_disp", disp_bank, 0);
        check("same_no_swap_cnt", swap_count, 2);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check("same_swap_state", state_dbg, ST_SWAP);
        tick();
        check("swap3_disp", disp_bank, 1);
        check("swap3_count", swap_count, 3);

        // reset during PENDING discards the pending swap
        ld_loaded = 1'b1;
        tick();
        ld_loaded = 1'b0;
        check("prerst_state", state_dbg, ST_PENDING);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_state", state_dbg, ST_LOADING);
        check("midrst_disp", disp_bank, 0);
        check("midrst_ready", ld_ready, 1);
        check("midrst_swap", swap_count, 0);
        check("midrst_drop", drop_count, 0);
        check("midrst_wen", mem_wen, 0);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
        check("midrst_fe_disp", disp_bank, 0);
        check("midrst_fe_swap", swap_count, 0);
        check("midrst_fe_state", state_dbg, ST_LOADING);

        // writes in PENDING-with-frame_end and in SWAP are both dropped
        ld_loaded = 1'b1;
        tick();
        ld_loaded = 1'b0;
        ld_wen = 1'b1; frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check("swapdrop_state", state_dbg, ST_SWAP);
        check("swapdrop_drop1", drop_count, 1);
        tick();
        ld_wen = 1'b0;
        check("swapdrop_drop2", drop_count, 2);
        check("swapdrop_wen", mem_wen, 0);
        check("swapdrop_disp", disp_bank, 1);
        check("swapdrop_swap", swap_count, 1);

        // ld_wen with ld_loaded: write accepted to old back bank (0)
        ld_wen = 1'b1; ld_loaded = 1'b1; ld_wrow = 3'd5; ld_wcol = 5'd17; ld_wdata = 24'h123456;
        tick();
        ld_wen = 1'b0; ld_loaded = 1'b0;
        check("wl_wen", mem_wen, 1);
        check("wl_bank", mem_wbank, 0);
        check("wl_row", mem_wrow, 5);
        check("wl_col", mem_wcol, 17);
        check("wl_data", mem_wdata, 24'h123456);
        check("wl_drop", drop_count, 2);
        check("wl_state", state_dbg, ST_PENDING);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
        check("wl_swap_disp", disp_bank, 0);
        check("wl_swap_cnt", swap_count, 2);

        // 256 load/swap cycles: swap_count wraps, disp_bank alternates
        exp_swap = 8'd2;
        exp_disp = 1'b0;
        for (int k = 0; k < 256; k++) begin
            ld_loaded = 1'b1;
            tick();
            ld_loaded = 1'b0;
            frame_end = 1'b1;
            tick();
            frame_end = 1'b0;
            tick();
            exp_swap = exp_swap + 8'd1;
            exp_disp = ~exp_disp;
            check("loop_swap", swap_count, exp_swap);
            check("loop_disp", disp_bank, exp_disp);
            if (k == 253) check("wrap_zero", swap_count, 0);
        end
        check("final_swap", swap_count, 2);
        check("final_disp", disp_bank, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
